// File: rtl/experiment_sequencer_pkg.sv
// Shared types for the multi-shot experiment sequencer: FSM states, the
// timing set handed to fsm_experiment, and the per-sequence configuration.
package experiment_sequencer_pkg;

    localparam int SEQ_CNT_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        START,
        WAIT,
        COOLDOWN,
        FINISH,
        ABORTED
    } seq_state_t;

    // Shot timing set consumed by fsm_experiment.
    typedef struct packed {
        logic [15:0] t_settle;
        logic [15:0] t_expose;
        logic [15:0] t_readout;
    } parameters_t;

    // Sequence configuration frozen at arm time.
    typedef struct packed {
        logic [15:0]          shot_count;
        logic [SEQ_CNT_W-1:0] cooldown;
        logic [SEQ_CNT_W-1:0] watchdog;
    } seq_cfg_t;

    // 16-bit increment that sticks at all-ones.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/experiment_sequencer_cycle_timer.sv
// Loadable down-counter. After a load of N on some edge, expired_o is high
// in the N-th cycle counted from that edge (N=0 behaves like N=1), so a
// state that leaves on expired_o lasts exactly max(N,1) cycles.
module cycle_timer #(
    parameter int CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             en_i,
    output logic             expired_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Load wins over counting; the count parks at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q <= CNT_W'(1));

endmodule

// File: rtl/experiment_sequencer.sv
// Multi-shot scheduler above fsm_experiment: runs cfg_shot_count shots with
// a cooldown between them, supervises each shot with a watchdog, retries
// failed shots and reports progress/fault/abort status.
//
// Interface to fsm_experiment: exp_start is a START_LEN-cycle strobe that
// begins a shot; the responder answers with a single-cycle exp_done or
// exp_fault pulse, which is only honoured in WAIT (fault wins a tie).
// exp_reset holds fsm_experiment in reset while idle/aborted and pulses for
// one cycle on entry to COOLDOWN.
module experiment_sequencer
    import experiment_sequencer_pkg::*;
#(
    parameter int START_LEN   = 4,
    parameter int MAX_RETRIES = 2,
    parameter int CNT_W       = SEQ_CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             arm,
    input  logic             abort,
    input  logic             clear,
    input  logic [15:0]      cfg_shot_count,
    input  logic [CNT_W-1:0] cfg_cooldown,
    input  logic [CNT_W-1:0] cfg_watchdog,
    input  parameters_t      cfg_par,
    output parameters_t      exp_par,
    output logic             exp_start,
    output logic             exp_reset,
    input  logic             exp_done,
    input  logic             exp_fault,
    output logic             busy,
    output logic             seq_done,
    output logic             aborted,
    output logic             cfg_error,
    output logic [15:0]      shots_done,
    output logic [15:0]      fault_count,
    output seq_state_t       state
);

    localparam logic [7:0] MAX_R = 8'(MAX_RETRIES);

    seq_state_t  state_q, state_d;
    logic        arm_q;
    seq_cfg_t    cfg_q, cfg_d;
    parameters_t par_q, par_d;
    logic [15:0] shots_q, shots_d;
    logic [15:0] faults_q, faults_d;
    logic [7:0]  retry_q, retry_d;
    logic        exp_start_q, exp_start_d;
    logic        exp_reset_q, exp_reset_d;
    logic        busy_q, busy_d;
    logic        seq_done_q, seq_done_d;
    logic        aborted_q, aborted_d;
    logic        cfg_error_q, cfg_error_d;

    logic             arm_rise;
    logic             shot_fault;
    logic             wd_load, wd_en, wd_expired;
    logic             ph_load, ph_en, ph_expired;
    logic [CNT_W-1:0] ph_val;

    assign arm_rise   = arm & ~arm_q;
    assign shot_fault = exp_fault | (wd_expired & (cfg_q.watchdog != '0));

    // Watchdog is armed on the edge that enters START and runs through WAIT.
    assign wd_load = (state_d == START) && (state_q != START);
    assign wd_en   = (state_q == START) || (state_q == WAIT);

    // Phase timer times both the start strobe and the cooldown.
    assign ph_load = (state_d != state_q) && ((state_d == START) || (state_d == COOLDOWN));
    assign ph_val  = (state_d == START) ? CNT_W'(START_LEN) : CNT_W'(cfg_q.cooldown);
    assign ph_en   = (state_q == START) || (state_q == COOLDOWN);

    cycle_timer #(.CNT_W(CNT_W)) u_watchdog (
        .clock      (clock),
        .reset      (reset),
        .load_i     (wd_load),
        .load_val_i (CNT_W'(cfg_q.watchdog)),
        .en_i       (wd_en),
        .expired_o  (wd_expired)
    );

    cycle_timer #(.CNT_W(CNT_W)) u_phase (
        .clock      (clock),
        .reset      (reset),
        .load_i     (ph_load),
        .load_val_i (ph_val),
        .en_i       (ph_en),
        .expired_o  (ph_expired)
    );

    // Next-state, counters and registered outputs derived from the next state.
    always_comb begin
        state_d     = state_q;
        cfg_d       = cfg_q;
        par_d       = par_q;
        shots_d     = shots_q;
        faults_d    = faults_q;
        retry_d     = retry_q;
        cfg_error_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (arm_rise) begin
                    if (cfg_shot_count == 16'd0) begin
                        cfg_error_d = 1'b1;
                    end else begin
                        state_d          = LATCH;
                        cfg_d.shot_count = cfg_shot_count;
                        cfg_d.cooldown   = SEQ_CNT_W'(cfg_cooldown);
                        cfg_d.watchdog   = SEQ_CNT_W'(cfg_watchdog);
                        par_d            = cfg_par;
                        shots_d          = 16'd0;
                        faults_d         = 16'd0;
                        retry_d          = 8'd0;
                    end
                end
            end
            LATCH: state_d = START;
            START: begin
                if (ph_expired) state_d = WAIT;
            end
            WAIT: begin
                if (shot_fault) begin
                    faults_d = sat_inc16(faults_q);
                    if (retry_q < MAX_R) begin
                        retry_d = retry_q + 8'd1;
                        state_d = COOLDOWN;
                    end else begin
                        state_d = ABORTED;
                    end
                end else if (exp_done) begin
                    shots_d = shots_q + 16'd1;
                    retry_d = 8'd0;
                    state_d = ((shots_q + 16'd1) == cfg_q.shot_count) ? FINISH : COOLDOWN;
                end
            end
            COOLDOWN: begin
                if (ph_expired) state_d = START;
            end
            FINISH:  state_d = IDLE;
            ABORTED: begin
                if (clear) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // abort overrides anything else that happened this cycle
        if (abort && (state_q != IDLE) && (state_q != ABORTED)) begin
            state_d  = ABORTED;
            shots_d  = shots_q;
            faults_d = faults_q;
            retry_d  = retry_q;
        end

        exp_start_d = (state_d == START);
        exp_reset_d = (state_d == IDLE) || (state_d == ABORTED) ||
                      ((state_d == COOLDOWN) && (state_q != COOLDOWN));
        busy_d      = (state_d != IDLE);
        seq_done_d  = (state_d == FINISH);
        aborted_d   = (state_d == ABORTED);
    end

    // State and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            arm_q       <= 1'b0;
            cfg_q       <= '0;
            par_q       <= '0;
            shots_q     <= 16'd0;
            faults_q    <= 16'd0;
            retry_q     <= 8'd0;
            exp_start_q <= 1'b0;
            exp_reset_q <= 1'b1;
            busy_q      <= 1'b0;
            seq_done_q  <= 1'b0;
            aborted_q   <= 1'b0;
            cfg_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            arm_q       <= arm;
            cfg_q       <= cfg_d;
            par_q       <= par_d;
            shots_q     <= shots_d;
            faults_q    <= faults_d;
            retry_q     <= retry_d;
            exp_start_q <= exp_start_d;
            exp_reset_q <= exp_reset_d;
            busy_q      <= busy_d;
            seq_done_q  <= seq_done_d;
            aborted_q   <= aborted_d;
            cfg_error_q <= cfg_error_d;
        end
    end

    assign state       = state_q;
    assign exp_par     = par_q;
    assign exp_start   = exp_start_q;
    assign exp_reset   = exp_reset_q;
    assign busy        = busy_q;
    assign seq_done    = seq_done_q;
    assign aborted     = aborted_q;
    assign cfg_error   = cfg_error_q;
    assign shots_done  = shots_q;
    assign fault_count = faults_q;

endmodule

// File: tb/tb_experiment_sequencer.sv
// Bench for experiment_sequencer: directed sequences with a responder that
// stands in for fsm_experiment, and an event scoreboard fed by a monitor.
module tb_experiment_sequencer;
  import experiment_sequencer_pkg::*;

  localparam int EV_W = 64;
  localparam logic [3:0] EV_START   = 4'd1;
  localparam logic [3:0] EV_SEQDONE = 4'd2;
  localparam logic [3:0] EV_ABORT   = 4'd3;
  localparam logic [3:0] EV_CFGERR  = 4'd4;
  localparam int R_DONE  = 0;
  localparam int R_FAULT = 1;
  localparam int R_NONE  = 2;
  localparam int R_BOTH  = 3;

  logic        clock, reset, arm, abort, clear;
  logic [15:0] cfg_shot_count;
  logic [31:0] cfg_cooldown, cfg_watchdog;
  parameters_t cfg_par, exp_par;
  logic        exp_start, exp_reset, exp_done, exp_fault;
  logic        busy, seq_done, aborted, cfg_error;
  logic [15:0] shots_done, fault_count;
  seq_state_t  state;

  int checks = 0;
  int errors = 0;
  logic [EV_W-1:0] exp_q[$];

  int resp_mode[16];
  int resp_delay[16];
  int resp_idx = 0;

  parameters_t par_a, par_b;

  experiment_sequencer dut (
    .clock(clock), .reset(reset), .arm(arm), .abort(abort), .clear(clear),
    .cfg_shot_count(cfg_shot_count), .cfg_cooldown(cfg_cooldown),
    .cfg_watchdog(cfg_watchdog), .cfg_par(cfg_par), .exp_par(exp_par),
    .exp_start(exp_start), .exp_reset(exp_reset), .exp_done(exp_done),
    .exp_fault(exp_fault), .busy(busy), .seq_done(seq_done),
    .aborted(aborted), .cfg_error(cfg_error), .shots_done(shots_done),
    .fault_count(fault_count), .state(state)
  );

  // clock / reset: period 5
  initial clock = 1'b0;
  always begin
    #3 clock = 1'b1;
    #2 clock = 1'b0;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation still running, required finish");
    $fatal(1);
  end

  function automatic logic [EV_W-1:0] mk_ev(input logic [3:0] t, input logic [15:0] f1,
                                            input logic [15:0] f2, input logic [27:0] f3);
    return {t, f1, f2, f3};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic sb_check(input string name, input logic [EV_W-1:0] act);
    logic [EV_W-1:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got unexpected event %0h expected none", name, act);
    end else begin
      e = exp_q.pop_front();
      chk(name, act, e);
    end
  endtask

  // monitor: turns output activity into events and checks them in order
  logic st_prev = 1'b0, busy_prev = 1'b0, ab_prev = 1'b0, sd_prev = 1'b0, ce_prev = 1'b0;
  int gap_cnt = 0, rise_gap = 0, st_len = 0, sd_len = 0, ce_len = 0;
  always @(negedge clock) begin
    if (reset) begin
      st_prev = 1'b0; busy_prev = 1'b0; ab_prev = 1'b0; sd_prev = 1'b0; ce_prev = 1'b0;
      gap_cnt = 0; st_len = 0; sd_len = 0; ce_len = 0;
    end else begin
      gap_cnt++;
      if (busy && !busy_prev) gap_cnt = 0;
      if (exp_start && !st_prev) begin
        rise_gap = gap_cnt;
        gap_cnt  = 0;
        st_len   = 0;
      end
      if (exp_start) st_len++;
      if (!exp_start && st_prev)
        sb_check("start_pulse", mk_ev(EV_START, 16'(st_len), 16'd0, 28'(rise_gap)));
      if (seq_done) sd_len++;
      if (!seq_done && sd_prev) begin
        sb_check("seq_done", mk_ev(EV_SEQDONE, shots_done, fault_count,
                                   {7'd0, aborted, 20'(sd_len)}));
        sd_len = 0;
      end
      if (aborted && !ab_prev)
        sb_check("abort_entry", mk_ev(EV_ABORT, shots_done, fault_count,
                                      {exp_reset, exp_start, 6'd0, 20'(gap_cnt)}));
      if (cfg_error) ce_len++;
      if (!cfg_error && ce_prev) begin
        sb_check("cfg_error", mk_ev(EV_CFGERR, 16'(ce_len), {15'd0, busy}, 28'd0));
        ce_len = 0;
      end
      st_prev = exp_start; busy_prev = busy; ab_prev = aborted;
      sd_prev = seq_done;  ce_prev = cfg_error;
    end
  end

  // responder standing in for fsm_experiment: answers D cycles into WAIT
  initial begin
    logic r_prev;
    int k, m, d;
    exp_done = 1'b0;
    exp_fault = 1'b0;
    r_prev = 1'b0;
    forever begin
      @(negedge clock);
      if (reset) begin
        r_prev = 1'b0;
      end else begin
        if (r_prev && !exp_start && !aborted) begin
          k = resp_idx;
          resp_idx++;
          m = resp_mode[k % 16];
          d = resp_delay[k % 16];
          if (m != R_NONE) begin
            repeat (d - 1) @(negedge clock);
            exp_done  = (m == R_DONE)  || (m == R_BOTH);
            exp_fault = (m == R_FAULT) || (m == R_BOTH);
            @(negedge clock);
            exp_done  = 1'b0;
            exp_fault = 1'b0;
          end
        end
        r_prev = exp_start;
      end
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic arm_pulse();
    arm = 1'b1;
    tick(1);
    arm = 1'b0;
  endtask

  task automatic clear_pulse();
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    tick(1);
  endtask

  task automatic set_resp(input int idx, input int mode, input int delay);
    resp_mode[idx]  = mode;
    resp_delay[idx] = delay;
  endtask

  task automatic setup(input logic [15:0] shots, input logic [31:0] cd, input logic [31:0] wd);
    cfg_shot_count = shots;
    cfg_cooldown   = cd;
    cfg_watchdog   = wd;
    cfg_par        = par_a;
    resp_idx       = 0;
  endtask

  task automatic wait_empty(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick(1);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d events still pending after %0d cycles, required 0", name, exp_q.size(), budget);
      exp_q.delete();
    end
  endtask

  task automatic push_start(input int len, input int gap);
    exp_q.push_back(mk_ev(EV_START, 16'(len), 16'd0, 28'(gap)));
  endtask

  initial begin
    int n;
    logic p;
    par_a = '{t_settle: 16'h0011, t_expose: 16'h0222, t_readout: 16'h3033};
    par_b = '{t_settle: 16'hAAAA, t_expose: 16'hBBBB, t_readout: 16'hCCCC};
    for (int i = 0; i < 16; i++) set_resp(i, R_NONE, 1);
    reset = 1'b1; arm = 1'b0; abort = 1'b0; clear = 1'b0;
    cfg_shot_count = 16'd0; cfg_cooldown = 32'd0; cfg_watchdog = 32'd0; cfg_par = '0;
    tick(3);
    chk("rst_state", 64'(state), 64'(IDLE));
    chk("rst_exp_reset", 64'(exp_reset), 64'd1);
    chk("rst_flags", 64'({exp_start, busy, seq_done, aborted, cfg_error}), 64'd0);
    chk("rst_counts", 64'({shots_done, fault_count}), 64'd0);
    chk("rst_exp_par", 64'(exp_par), 64'd0);
    reset = 1'b0;
    tick(2);

    // 1: three clean shots, cfg changes mid-sequence are ignored
    setup(16'd3, 32'd20, 32'd0);
    for (int i = 0; i < 3; i++) set_resp(i, R_DONE, 50);
    push_start(4, 1); push_start(4, 74); push_start(4, 74);
    exp_q.push_back(mk_ev(EV_SEQDONE, 16'd3, 16'd0, 28'd1));
    arm_pulse();
    tick(3);
    cfg_par = par_b; cfg_shot_count = 16'd5; cfg_cooldown = 32'd1;
    tick(2);
    chk("t1_exp_par_frozen", 64'(exp_par), 64'(par_a));
    chk("t1_busy_reset", 64'({busy, exp_reset}), 64'b10);
    wait_empty("t1_events", 400);
    chk("t1_idle", 64'({busy, 1'b0, state}), 64'(IDLE));

    // 2: shot 2 faults twice then passes
    setup(16'd3, 32'd10, 32'd0);
    set_resp(0, R_DONE, 20); set_resp(1, R_FAULT, 20); set_resp(2, R_FAULT, 20);
    set_resp(3, R_DONE, 20); set_resp(4, R_DONE, 20);
    push_start(4, 1);
    for (int i = 0; i < 4; i++) push_start(4, 34);
    exp_q.push_back(mk_ev(EV_SEQDONE, 16'd3, 16'd2, 28'd1));
    arm_pulse();
    wait_empty("t2_events", 400);

    // 3: no answer, watchdog 100, retries exhausted
    setup(16'd2, 32'd10, 32'd100);
    for (int i = 0; i < 3; i++) set_resp(i, R_NONE, 1);
    push_start(4, 1); push_start(4, 110); push_start(4, 110);
    exp_q.push_back(mk_ev(EV_ABORT, 16'd0, 16'd3, {1'b1, 1'b0, 6'd0, 20'd100}));
    arm_pulse();
    wait_empty("t3_events", 600);
    tick(1);
    chk("t3_aborted_state", 64'(state), 64'(ABORTED));
    chk("t3_aborted_outs", 64'({aborted, exp_reset, exp_start, busy}), 64'b1101);
    clear_pulse();
    chk("t3_clear_state", 64'(state), 64'(IDLE));
    chk("t3_clear_outs", 64'({busy, aborted}), 64'd0);

    // 4: abort during the second start strobe
    setup(16'd3, 32'd10, 32'd0);
    for (int i = 0; i < 3; i++) set_resp(i, R_DONE, 20);
    push_start(4, 1); push_start(2, 34);
    exp_q.push_back(mk_ev(EV_ABORT, 16'd1, 16'd0, {1'b1, 1'b0, 6'd0, 20'd2}));
    arm_pulse();
    n = 0; p = 1'b0;
    for (int c = 0; c < 300 && n < 2; c++) begin
      tick(1);
      if (exp_start && !p) n++;
      p = exp_start;
    end
    chk("t4_second_strobe_seen", 64'(n), 64'd2);
    tick(1);
    abort = 1'b1;
    tick(1);
    chk("t4_state", 64'(state), 64'(ABORTED));
    chk("t4_start_low", 64'({exp_start, shots_done}), 64'd1);
    wait_empty("t4_events", 20);
    abort = 1'b0;
    clear_pulse();
    chk("t4_clear_state", 64'(state), 64'(IDLE));

    // 5: zero shot count, then re-arm while busy
    setup(16'd0, 32'd10, 32'd0);
    exp_q.push_back(mk_ev(EV_CFGERR, 16'd1, 16'd0, 28'd0));
    arm_pulse();
    tick(3);
    chk("t5_not_busy", 64'({busy, 1'b0, state}), 64'(IDLE));
    wait_empty("t5_cfgerr", 10);
    setup(16'd2, 32'd10, 32'd0);
    for (int i = 0; i < 2; i++) set_resp(i, R_DONE, 20);
    push_start(4, 1); push_start(4, 34);
    exp_q.push_back(mk_ev(EV_SEQDONE, 16'd2, 16'd0, 28'd1));
    arm_pulse();
    tick(10);
    cfg_shot_count = 16'd7;
    arm_pulse();
    wait_empty("t5_events", 200);
    tick(2);
    chk("t5_idle_after", 64'({busy, shots_done}), 64'd2);

    // 6: simultaneous done+fault is a fault; async reset while in WAIT
    setup(16'd2, 32'd5, 32'd0);
    set_resp(0, R_BOTH, 10); set_resp(1, R_DONE, 10); set_resp(2, R_NONE, 1);
    push_start(4, 1); push_start(4, 19); push_start(4, 19);
    arm_pulse();
    wait_empty("t6_events", 200);
    tick(5);
    chk("t6_wait_state", 64'(state), 64'(WAIT));
    chk("t6_counts", 64'({shots_done, fault_count}), 64'h0001_0001);
    #1 reset = 1'b1;
    #1;
    chk("t6_rst_state", 64'(state), 64'(IDLE));
    chk("t6_rst_outs", 64'({exp_reset, exp_start, busy, seq_done, aborted, cfg_error}), 64'b100000);
    chk("t6_rst_counts", 64'({shots_done, fault_count}), 64'd0);
    chk("t6_rst_exp_par", 64'(exp_par), 64'd0);
    tick(2);
    reset = 1'b0;
    tick(5);
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
